scope_call_responder: RTL and testbench

- Callee side of a hierarchical function-call interface. Accepts call requests naming a function by relative or absolute hierarchical path from a caller scope.
- Resolves the target scope with a cycle-by-cycle upward scope search and returns that scope's function result.
- Models a fixed four-scope hierarchy: top, top.blk, top.i, top.i.blk. Each scope defines function f, and f ignores its argument.
- Serves as the responder end for hierarchical-call test benches.

---
 rtl/scope_call_responder_if.sv | 48 ++++
 rtl/scope_call_responder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_scope_call_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/scope_call_responder_if.sv
// ---------------------------------------------------------------------------
// scope_call_responder_if
//   Request/response bundle between a hierarchical-call issuer (master) and
//   the scope_call_responder (slave).
//   Request : req_valid/req_ready handshake, req_caller (caller scope code),
//             req_path (relative name code), req_abs (name starts at "top."),
//             req_arg (carried but never used), req_tag (echoed back).
//   Response: resp_valid/resp_ready handshake, resp_data, resp_tag, resp_err.
//   Optional: resp_steps (3 bits) when SCOPE_STEP_COUNT_EN is defined.
// ---------------------------------------------------------------------------
interface scope_call_responder_if #(
  parameter int unsigned TW = 32'd4,
  parameter int unsigned RW = 32'd8
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_caller;
  logic [1:0]    req_path;
  logic          req_abs;
  logic [RW-1:0] req_arg;
  logic [TW-1:0] req_tag;
  logic          resp_valid;
  logic          resp_ready;
  logic [RW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_err;
`ifdef SCOPE_STEP_COUNT_EN
  logic [2:0]    resp_steps;

  modport master (
    output req_valid, req_caller, req_path, req_abs, req_arg, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_err, resp_steps
  );
  modport slave (
    input  req_valid, req_caller, req_path, req_abs, req_arg, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, resp_err, resp_steps
  );
`else
  modport master (
    output req_valid, req_caller, req_path, req_abs, req_arg, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_err
  );
  modport slave (
    input  req_valid, req_caller, req_path, req_abs, req_arg, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, resp_err
  );
`endif
endinterface

// File: rtl/scope_call_responder.sv
// ---------------------------------------------------------------------------
// scope_call_responder
//   Callee end of a hierarchical function-call interface for the fixed scope
//   tree top, top.blk, top.i, top.i.blk. Requests are queued in an in-order
//   FIFO, resolved by an upward scope search (one level per cycle) and
//   answered with the target scope's constant result for f.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (drops queued and in-flight calls)
//   bus  - scope_call_responder_if.slave (request and response channels)
// Optional feature:
//   SCOPE_STEP_COUNT_EN - adds bus.resp_steps, the RESOLVE cycles used (1..3)
// ---------------------------------------------------------------------------
module scope_call_responder #(
  parameter int unsigned DEPTH      = 32'd4,
  parameter int unsigned TW         = 32'd4,
  parameter int unsigned RW         = 32'd8,
  parameter int unsigned RES0       = 32'd3,
  parameter int unsigned RES1       = 32'd4,
  parameter int unsigned RES2       = 32'd1,
  parameter int unsigned RES3       = 32'd2,
  parameter logic [3:0]  SCOPE_MASK = 4'b1111
) (
  input logic                  clk,
  input logic                  rst,
  scope_call_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = TW + 32'd5;
  localparam logic [AW:0] ptr_one = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] sc_top  = 2'd0;
  localparam logic [1:0] sc_blk  = 2'd1;
  localparam logic [1:0] sc_i    = 2'd2;
  localparam logic [1:0] sc_iblk = 2'd3;

  // A scope exists only when it and every ancestor are generated.
  localparam logic [3:0] en_eff = {
    SCOPE_MASK[0] & SCOPE_MASK[2] & SCOPE_MASK[3],
    SCOPE_MASK[0] & SCOPE_MASK[2],
    SCOPE_MASK[0] & SCOPE_MASK[1],
    SCOPE_MASK[0]
  };

  typedef enum logic [1:0] {
    st_idle    = 2'd0,
    st_resolve = 2'd1,
    st_respond = 2'd2
  } state_t;

  function automatic logic [1:0] parent_of(input logic [1:0] s);
    case (s)
      sc_iblk: parent_of = sc_i;
      default: parent_of = sc_top;
    endcase
  endfunction

  function automatic logic [RW-1:0] result_of(input logic [1:0] s);
    case (s)
      sc_top:  result_of = RW'(RES0);
      sc_blk:  result_of = RW'(RES1);
      sc_i:    result_of = RW'(RES2);
      default: result_of = RW'(RES3);
    endcase
  endfunction

  // ---------------- request FIFO ----------------
  logic [EW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic          full_s, empty_s, push_s, pop_s;
  logic [EW-1:0] head_s;
  logic          unused_arg_s;

  assign empty_s       = (wr_ptr_r == rd_ptr_r);
  assign full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_s        = bus.req_valid && !full_s;
  assign bus.req_ready = !full_s;
  assign head_s        = mem_r[rd_ptr_r[AW-1:0]];
  assign unused_arg_s  = ^bus.req_arg;

  // FIFO storage; entry = {caller, path, abs, tag}. The argument is never kept.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {bus.req_caller, bus.req_path, bus.req_abs, bus.req_tag};
    end
  end

  // FIFO pointers; a full FIFO refuses pushes even when popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + ptr_one;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + ptr_one;
    end
  end

  // ---------------- working request and search state ----------------
  state_t        state_r, state_nxt_s;
  logic [1:0]    w_caller_r, w_path_r, cs_r;
  logic          w_abs_r;
  logic [TW-1:0] w_tag_r;
  logic          hit_s, load_s, step_s, finish_s, fin_err_s, release_s;
  logic [1:0]    target_s;
`ifdef SCOPE_STEP_COUNT_EN
  logic [2:0]    steps_r;
  logic [2:0]    resp_steps_r;
`endif

  // Does the current search scope resolve the first name component?
  always_comb begin
    hit_s    = 1'b0;
    target_s = cs_r;
    case (w_path_r)
      2'd0: begin                                   // "f"
        hit_s    = en_eff[cs_r];
        target_s = cs_r;
      end
      2'd1: begin                                   // "blk.f": child blk
        if (cs_r == sc_top) begin
          hit_s    = en_eff[1];
          target_s = sc_blk;
        end else if (cs_r == sc_i) begin
          hit_s    = en_eff[3];
          target_s = sc_iblk;
        end else begin
          hit_s    = 1'b0;
          target_s = cs_r;
        end
      end
      2'd2: begin                                   // "i.f": child i only under top
        hit_s    = (cs_r == sc_top) && en_eff[2];
        target_s = sc_i;
      end
      2'd3: begin                                   // "i.blk.f": through top.i
        hit_s    = (cs_r == sc_top) && en_eff[3];
        target_s = sc_iblk;
      end
      default: begin
        hit_s    = 1'b0;
        target_s = cs_r;
      end
    endcase
  end

  // FSM next state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    fin_err_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      st_idle: begin
        if (!empty_s) begin
          load_s      = 1'b1;
          state_nxt_s = st_resolve;
        end else begin
          state_nxt_s = st_idle;
        end
      end
      st_resolve: begin
        if (!w_abs_r && !en_eff[w_caller_r]) begin
          finish_s  = 1'b1;
          fin_err_s = 1'b1;
        end else if (hit_s) begin
          finish_s  = 1'b1;
          fin_err_s = 1'b0;
        end else if (w_abs_r || (cs_r == sc_top)) begin
          finish_s  = 1'b1;
          fin_err_s = 1'b1;
        end else begin
          step_s    = 1'b1;
        end
        state_nxt_s = finish_s ? st_respond : st_resolve;
      end
      st_respond: begin
        if (bus.resp_ready) begin
          release_s = 1'b1;
          // The accept edge doubles as the load cycle for a queued request.
          if (!empty_s) begin
            load_s      = 1'b1;
            state_nxt_s = st_resolve;
          end else begin
            state_nxt_s = st_idle;
          end
        end else begin
          state_nxt_s = st_respond;
        end
      end
      default: begin
        state_nxt_s = st_idle;
      end
    endcase
  end

  assign pop_s = load_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= st_idle;
    else     state_r <= state_nxt_s;
  end

  // Working request capture and upward search scope.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_caller_r <= 2'd0;
      w_path_r   <= 2'd0;
      w_abs_r    <= 1'b0;
      w_tag_r    <= {TW{1'b0}};
      cs_r       <= sc_top;
`ifdef SCOPE_STEP_COUNT_EN
      steps_r    <= 3'd0;
`endif
    end else if (load_s) begin
      w_caller_r <= head_s[EW-1 -: 2];
      w_path_r   <= head_s[EW-3 -: 2];
      w_abs_r    <= head_s[TW];
      w_tag_r    <= head_s[TW-1:0];
      cs_r       <= head_s[TW] ? sc_top : head_s[EW-1 -: 2];
`ifdef SCOPE_STEP_COUNT_EN
      steps_r    <= 3'd1;
`endif
    end else if (step_s) begin
      cs_r       <= parent_of(cs_r);
`ifdef SCOPE_STEP_COUNT_EN
      steps_r    <= steps_r + 3'd1;
`endif
    end
  end

  // ---------------- response registers ----------------
  logic          resp_valid_r, resp_err_r;
  logic [RW-1:0] resp_data_r;
  logic [TW-1:0] resp_tag_r;

  // Response capture; values stay put while the consumer back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= {RW{1'b0}};
      resp_tag_r   <= {TW{1'b0}};
      resp_err_r   <= 1'b0;
`ifdef SCOPE_STEP_COUNT_EN
      resp_steps_r <= 3'd0;
`endif
    end else if (finish_s) begin
      resp_valid_r <= 1'b1;
      resp_data_r  <= fin_err_s ? {RW{1'b0}} : result_of(target_s);
      resp_tag_r   <= w_tag_r;
      resp_err_r   <= fin_err_s;
`ifdef SCOPE_STEP_COUNT_EN
      resp_steps_r <= steps_r;
`endif
    end else if (release_s) begin
      resp_valid_r <= 1'b0;
    end
  end

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_tag   = resp_tag_r;
  assign bus.resp_err   = resp_err_r;
`ifdef SCOPE_STEP_COUNT_EN
  assign bus.resp_steps = resp_steps_r;
`endif

endmodule

// File: tb/tb_scope_call_responder.sv
// ---------------------------------------------------------------------------
// tb_scope_call_responder
//   Directed bench for scope_call_responder. Two instances share the request
//   stimulus: u0 with every scope generated, u1 with SCOPE_MASK=4'b1011
//   (top.i and therefore top.i.blk absent). Outputs are sampled on the
//   falling edge; inputs are also changed there.
// ---------------------------------------------------------------------------
module tb_scope_call_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, resp_ready, req_abs;
  logic [1:0] req_caller, req_path;
  logic [7:0] req_arg;
  logic [3:0] req_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scope_call_responder_if #(.TW(32'd4), .RW(32'd8)) if0 ();
  scope_call_responder_if #(.TW(32'd4), .RW(32'd8)) if1 ();

  assign if0.req_valid  = req_valid;
  assign if0.req_caller = req_caller;
  assign if0.req_path   = req_path;
  assign if0.req_abs    = req_abs;
  assign if0.req_arg    = req_arg;
  assign if0.req_tag    = req_tag;
  assign if0.resp_ready = resp_ready;
  assign if1.req_valid  = req_valid;
  assign if1.req_caller = req_caller;
  assign if1.req_path   = req_path;
  assign if1.req_abs    = req_abs;
  assign if1.req_arg    = req_arg;
  assign if1.req_tag    = req_tag;
  assign if1.resp_ready = resp_ready;

  scope_call_responder #(.DEPTH(32'd4), .TW(32'd4), .RW(32'd8), .SCOPE_MASK(4'b1111))
    u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  scope_call_responder #(.DEPTH(32'd4), .TW(32'd4), .RW(32'd8), .SCOPE_MASK(4'b1011))
    u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic rv(input int u);
    return (u != 0) ? if1.resp_valid : if0.resp_valid;
  endfunction
  function automatic logic [7:0] rdat(input int u);
    return (u != 0) ? if1.resp_data : if0.resp_data;
  endfunction
  function automatic logic [3:0] rtag(input int u);
    return (u != 0) ? if1.resp_tag : if0.resp_tag;
  endfunction
  function automatic logic rerr(input int u);
    return (u != 0) ? if1.resp_err : if0.resp_err;
  endfunction
  function automatic logic rrdy(input int u);
    return (u != 0) ? if1.req_ready : if0.req_ready;
  endfunction
`ifdef SCOPE_STEP_COUNT_EN
  function automatic logic [2:0] rsteps(input int u);
    return (u != 0) ? if1.resp_steps : if0.resp_steps;
  endfunction
`endif

  // One call on an idle responder; checks latency (edges after accept),
  // data, error, tag and (optionally) resolve steps on unit u.
  task automatic do_req(input int u, input string nm, input logic [1:0] c, input logic [1:0] p,
                        input logic a, input logic [3:0] t, input logic [7:0] ed,
                        input logic ee, input int el, input int es);
    int   cyc;
    logic got;
    @(negedge clk);
    req_caller = c; req_path = p; req_abs = a; req_tag = t; req_arg = 8'hA5;
    req_valid  = 1'b1; resp_ready = 1'b1;
    check_eq({nm, "_rdy"}, rrdy(u), 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    got = rv(u);
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = rv(u);
    end
    check_eq({nm, "_seen"}, got, 1'b1);
    check_eq({nm, "_lat"}, cyc - 1, el);
    check_eq({nm, "_data"}, rdat(u), ed);
    check_eq({nm, "_err"}, rerr(u), ee);
    check_eq({nm, "_tag"}, rtag(u), t);
`ifdef SCOPE_STEP_COUNT_EN
    check_eq({nm, "_steps"}, rsteps(u), es);
`else
    if (es < 0) $display("note: negative step count requested");
`endif
    repeat (4) @(negedge clk);
  endtask

  // Watchdog in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] exp_d [6] = '{8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd3};
  logic [3:0] exp_t [6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  logic [1:0] t4_path [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
  logic       t4_abs  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  // Directed scenario sequence.
  initial begin
    int  j, guard, seen;
    logic acc;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_caller = 2'd0; req_path = 2'd0; req_abs = 1'b0; req_arg = 8'd0; req_tag = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_valid", if0.resp_valid, 1'b0);
    check_eq("rst_data", if0.resp_data, 8'd0);
    check_eq("rst_tag", if0.resp_tag, 4'd0);
    check_eq("rst_err", if0.resp_err, 1'b0);
    check_eq("rst_ready", if0.req_ready, 1'b1);
`ifdef SCOPE_STEP_COUNT_EN
    check_eq("rst_steps", if0.resp_steps, 3'd0);
`endif

    // Relative searches, full hierarchy.
    do_req(0, "t1_top_f",      2'd0, 2'd0, 1'b0, 4'd1, 8'd3, 1'b0, 2, 1);
    do_req(0, "t2_iblk_blkf",  2'd3, 2'd1, 1'b0, 4'd2, 8'd2, 1'b0, 3, 2);
    do_req(0, "t3_blk_if",     2'd1, 2'd2, 1'b0, 4'd3, 8'd1, 1'b0, 3, 2);
    do_req(0, "t3b_i_iblkf",   2'd2, 2'd3, 1'b0, 4'd4, 8'd2, 1'b0, 3, 2);
    do_req(0, "t3c_iblk_if",   2'd3, 2'd2, 1'b0, 4'd11, 8'd1, 1'b0, 4, 3);

    // Partial hierarchy (top.i absent).
    do_req(1, "m_top_iblkf",   2'd0, 2'd3, 1'b0, 4'd12, 8'd0, 1'b1, 2, 1);
    do_req(1, "m_iblk_caller", 2'd3, 2'd0, 1'b0, 4'd13, 8'd0, 1'b1, 2, 1);
    do_req(1, "m_blk_f",       2'd1, 2'd0, 1'b0, 4'd14, 8'd4, 1'b0, 2, 1);
    do_req(1, "m_abs_if",      2'd1, 2'd2, 1'b1, 4'd15, 8'd0, 1'b1, 2, 1);
    do_req(1, "m_blk_blkf",    2'd1, 2'd1, 1'b0, 4'd0, 8'd4, 1'b0, 3, 2);

    // Back-pressure: six requests, consumer stalled, FIFO fills after the 5th.
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_caller = 2'd0; req_path = t4_path[i]; req_abs = t4_abs[i]; req_tag = exp_t[i];
      req_valid  = 1'b1;
      check_eq("t4_ready_open", if0.req_ready, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    req_path = t4_path[5]; req_abs = t4_abs[5]; req_tag = exp_t[5];
    check_eq("t4_full", if0.req_ready, 1'b0);
    check_eq("t4_hold_valid", if0.resp_valid, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t4_still_full", if0.req_ready, 1'b0);
    check_eq("t4_hold_data", if0.resp_data, 8'd3);
    check_eq("t4_hold_tag", if0.resp_tag, 4'd5);
    resp_ready = 1'b1;
    j = 0; guard = 0; acc = 1'b0;
    while (j < 6 && guard < 80) begin
      if (if0.resp_valid) begin
        check_eq("t4_data", if0.resp_data, exp_d[j]);
        check_eq("t4_tag", if0.resp_tag, exp_t[j]);
        check_eq("t4_err", if0.resp_err, 1'b0);
        j++;
      end
      if (req_valid) begin
        if (acc) req_valid = 1'b0;
        else if (if0.req_ready) acc = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    check_eq("t4_count", j, 6);
    repeat (12) @(negedge clk);

    // Reset while resolving with two requests queued.
    req_caller = 2'd3; req_path = 2'd2; req_abs = 1'b0; req_tag = 4'd1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_tag = 4'd2;
    @(posedge clk);
    @(negedge clk);
    req_tag = 4'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("t5_pre_valid", if0.resp_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_valid", if0.resp_valid, 1'b0);
    check_eq("t5_ready", if0.req_ready, 1'b1);
    do_req(0, "t5_after", 2'd2, 2'd0, 1'b0, 4'd9, 8'd1, 1'b0, 2, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if0.resp_valid) seen++;
    end
    check_eq("t5_dropped", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
